// File: rtl/display_output_stage.sv
// rtl/display_output_stage.sv - timing alignment, blanking, ordered dither and truncation to panel width
module display_output_stage #(
  parameter int IN_W       = 8,
  parameter int OUT_W      = 4,
  parameter int SYNC_DELAY = 2,
  parameter bit H_POL      = 1'b0,
  parameter bit V_POL      = 1'b0
) (
  input  logic             i_pix_clk,
  input  logic             i_rst_n,
  input  logic             i_hs,
  input  logic             i_vs,
  input  logic             i_de,
  input  logic             i_frame,
  input  logic [IN_W-1:0]  i_red,
  input  logic [IN_W-1:0]  i_green,
  input  logic [IN_W-1:0]  i_blue,
  input  logic             i_dither_en,
  output logic             o_hs,
  output logic             o_vs,
  output logic             o_de,
  output logic             o_frame,
  output logic [OUT_W-1:0] o_red,
  output logic [OUT_W-1:0] o_green,
  output logic [OUT_W-1:0] o_blue
);

  localparam int DIFF      = IN_W - OUT_W;
  localparam bit DITHER_OK = (DIFF >= 2);
  localparam int TSH       = DITHER_OK ? DIFF - 2 : 0;

  // Timing bundle order: {frame, de, vs, hs}
  localparam logic [3:0] TIM_IDLE = {1'b0, 1'b0, ~V_POL, ~H_POL};

  logic [3:0] tim_in;
  logic [3:0] tim_d;
  logic       hs_d, vs_d, de_d, frame_d;

  assign tim_in = {i_frame, i_de, i_vs, i_hs};

  generate
    if (SYNC_DELAY == 0) begin : g_nodly
      assign tim_d = tim_in;
    end else begin : g_dly
      logic [3:0] sr_q [SYNC_DELAY];

      always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int k = 0; k < SYNC_DELAY; k++) sr_q[k] <= TIM_IDLE;
        end else begin
          sr_q[0] <= tim_in;
          for (int k = 1; k < SYNC_DELAY; k++) sr_q[k] <= sr_q[k-1];
        end
      end

      assign tim_d = sr_q[SYNC_DELAY-1];
    end
  endgenerate

  assign hs_d    = tim_d[0];
  assign vs_d    = tim_d[1];
  assign de_d    = tim_d[2];
  assign frame_d = tim_d[3];

  logic xp_q, yp_q, de_prev_q, dither_act_q;
  logic [1:0]      bayer;
  logic [IN_W-1:0] thr;

  always_comb begin
    bayer = 2'd0;
    case ({yp_q, xp_q})
      2'b00:   bayer = 2'd0;
      2'b01:   bayer = 2'd2;
      2'b10:   bayer = 2'd3;
      default: bayer = 2'd1;
    endcase
    thr = '0;
    if (DITHER_OK && dither_act_q) thr = IN_W'(bayer) << TSH;
  end

  // A carry out of the component width means the dithered value overflowed: clamp to full scale.
  function automatic logic [OUT_W-1:0] shade(input logic [IN_W-1:0] c, input logic [IN_W-1:0] t);
    logic [IN_W:0] sum;
    sum = {1'b0, c} + {1'b0, t};
    if (sum[IN_W]) return '1;
    return sum[IN_W-1 -: OUT_W];
  endfunction

  logic             o_hs_q, o_vs_q, o_de_q, o_frame_q;
  logic [OUT_W-1:0] o_red_q, o_green_q, o_blue_q;

  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      xp_q         <= 1'b0;
      yp_q         <= 1'b0;
      de_prev_q    <= 1'b0;
      dither_act_q <= 1'b0;
      o_hs_q       <= ~H_POL;
      o_vs_q       <= ~V_POL;
      o_de_q       <= 1'b0;
      o_frame_q    <= 1'b0;
      o_red_q      <= '0;
      o_green_q    <= '0;
      o_blue_q     <= '0;
    end else begin
      de_prev_q <= de_d;
      xp_q      <= de_d ? ~xp_q : 1'b0;
      if (frame_d)                yp_q <= 1'b0;
      else if (de_prev_q && !de_d) yp_q <= ~yp_q;
      if (frame_d) dither_act_q <= i_dither_en & DITHER_OK;
      o_hs_q    <= hs_d;
      o_vs_q    <= vs_d;
      o_de_q    <= de_d;
      o_frame_q <= frame_d;
      o_red_q   <= de_d ? shade(i_red,   thr) : '0;
      o_green_q <= de_d ? shade(i_green, thr) : '0;
      o_blue_q  <= de_d ? shade(i_blue,  thr) : '0;
    end
  end

  assign o_hs    = o_hs_q;
  assign o_vs    = o_vs_q;
  assign o_de    = o_de_q;
  assign o_frame = o_frame_q;
  assign o_red   = o_red_q;
  assign o_green = o_green_q;
  assign o_blue  = o_blue_q;

endmodule

// File: tb/tb_display_output_stage.sv
// tb/tb_display_output_stage.sv - directed bench for display_output_stage at IN_W=8, OUT_W=4, SYNC_DELAY=2
module tb_display_output_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_hs = 1'b1, i_vs = 1'b1, i_de = 1'b0, i_frame = 1'b0;
  logic [7:0] i_red = '0, i_green = '0, i_blue = '0;
  logic       i_dither_en = 1'b0;
  logic       o_hs, o_vs, o_de, o_frame;
  logic [3:0] o_red, o_green, o_blue;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [11:0] cap[$];

  display_output_stage #(.IN_W(8), .OUT_W(4), .SYNC_DELAY(2), .H_POL(1'b0), .V_POL(1'b0)) dut (
    .i_pix_clk(clk), .i_rst_n(rst_n),
    .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de), .i_frame(i_frame),
    .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
    .i_dither_en(i_dither_en),
    .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de), .o_frame(o_frame),
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_line(input int n, input logic [7:0] c);
    i_red = c; i_green = c; i_blue = c;
    i_de = 1'b1;
    repeat (n) begin tick(); if (o_de) cap.push_back({o_blue, o_green, o_red}); end
    i_de = 1'b0;
    repeat (5) begin tick(); if (o_de) cap.push_back({o_blue, o_green, o_red}); end
  endtask

  task automatic frame_pulse();
    i_frame = 1'b1;
    tick();
    i_frame = 1'b0;
    repeat (5) tick();
  endtask

  function automatic logic [11:0] pix(input int i);
    return (cap.size() > i) ? cap[i] : 12'hBAD;
  endfunction

  task automatic check_pattern(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                               input logic [3:0] e2, input logic [3:0] e3, input int base);
    logic [3:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_px%0d", tag, i), 32'(pix(base + i)), 32'({e[i], e[i], e[i]}));
  endtask

  initial begin
    repeat (2) tick();
    check("rst_hs", 32'(o_hs), 32'd1);
    check("rst_vs", 32'(o_vs), 32'd1);
    check("rst_de", 32'(o_de), 32'd0);
    check("rst_frame", 32'(o_frame), 32'd0);
    check("rst_red", 32'(o_red), 32'd0);

    rst_n = 1'b1;
    i_hs = 1'b0; i_de = 1'b1; i_red = 8'hFF; i_green = 8'hFF; i_blue = 8'hFF;
    repeat (3) tick();
    check("line_hs", 32'(o_hs), 32'd0);
    check("line_de", 32'(o_de), 32'd1);
    check("line_red", 32'(o_red), 32'hF);

    #2 rst_n = 1'b0;
    #1;
    check("async_hs", 32'(o_hs), 32'd1);
    check("async_vs", 32'(o_vs), 32'd1);
    check("async_de", 32'(o_de), 32'd0);
    check("async_red", 32'(o_red), 32'd0);
    check("async_blue", 32'(o_blue), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rel1_de", 32'(o_de), 32'd0);
    check("rel1_hs", 32'(o_hs), 32'd1);
    check("rel1_red", 32'(o_red), 32'd0);
    tick();
    check("rel2_de", 32'(o_de), 32'd0);
    check("rel2_hs", 32'(o_hs), 32'd1);
    tick();
    check("rel3_de", 32'(o_de), 32'd1);
    check("rel3_hs", 32'(o_hs), 32'd0);

    i_hs = 1'b1; i_de = 1'b0;
    repeat (5) tick();

    i_de = 1'b1;
    tick();
    tick();
    check("align_pre_de", 32'(o_de), 32'd0);
    check("align_pre_red", 32'(o_red), 32'd0);
    i_red = 8'hA7; i_green = 8'h5C; i_blue = 8'h31;
    tick();
    check("align_de", 32'(o_de), 32'd1);
    check("align_red", 32'(o_red), 32'hA);
    check("align_green", 32'(o_green), 32'h5);
    check("align_blue", 32'(o_blue), 32'h3);

    i_de = 1'b0; i_red = 8'hFF; i_green = 8'hFF; i_blue = 8'hFF;
    repeat (3) tick();
    check("blank_de", 32'(o_de), 32'd0);
    check("blank_red", 32'(o_red), 32'd0);
    check("blank_green", 32'(o_green), 32'd0);
    check("blank_blue", 32'(o_blue), 32'd0);
    repeat (3) tick();

    i_dither_en = 1'b1;
    i_frame = 1'b1;
    tick();
    i_frame = 1'b0;
    tick();
    check("frame_early", 32'(o_frame), 32'd0);
    tick();
    check("frame_out", 32'(o_frame), 32'd1);
    repeat (3) tick();
    cap.delete();
    run_line(4, 8'h18);
    run_line(4, 8'h18);
    check("dither_count", 32'(cap.size()), 32'd8);
    check_pattern("dither_l0", 4'h1, 4'h2, 4'h1, 4'h2, 0);
    check_pattern("dither_l1", 4'h2, 4'h1, 4'h2, 4'h1, 4);

    run_line(4, 8'h18);
    cap.delete();
    run_line(4, 8'hFE);
    check("sat_y1x0", 32'(pix(0)), 32'hFFF);
    check("sat_y1x1", 32'(pix(1)), 32'hFFF);

    i_dither_en = 1'b0;
    frame_pulse();
    i_dither_en = 1'b1;
    cap.delete();
    run_line(4, 8'h18);
    run_line(4, 8'h18);
    check("mid_count", 32'(cap.size()), 32'd8);
    check_pattern("mid_l0", 4'h1, 4'h1, 4'h1, 4'h1, 0);
    check_pattern("mid_l1", 4'h1, 4'h1, 4'h1, 4'h1, 4);
    frame_pulse();
    cap.delete();
    run_line(4, 8'h18);
    check_pattern("next_frame", 4'h1, 4'h2, 4'h1, 4'h2, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/display_output_stage.md
DISPLAY_OUTPUT_STAGE -- requirements
Module: display_output_stage

Interface
REQ-001 SHALL have parameter IN_W, default 8, input colour component width.
REQ-002 SHALL have parameter OUT_W, default 4, output colour component width; legal range 1..IN_W.
REQ-003 SHALL have parameter SYNC_DELAY, default 2, cycles of timing delay that align timing with colour from pipelined generators; legal range 0..7.
REQ-004 SHALL have parameters H_POL and V_POL, default 0, sync active level (1 = active-high).
REQ-005 SHALL have port i_pix_clk, input, 1, pixel clock; the single clock, all state on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have ports i_hs, i_vs, i_de, i_frame, input, 1 each, raw timing from the timing generator.
REQ-008 SHALL have ports i_red, i_green, i_blue, input, IN_W each, generator colour.
REQ-009 SHALL have port i_dither_en, input, 1, ordered-dither request.
REQ-010 SHALL have ports o_hs, o_vs, o_de, o_frame, output, 1 each, aligned and registered timing.
REQ-011 SHALL have ports o_red, o_green, o_blue, output, OUT_W each, registered colour.

Function
REQ-012 SHALL delay i_hs, i_vs, i_de and i_frame through a SYNC_DELAY-stage shift register (hs_d, vs_d, de_d, frame_d); SYNC_DELAY=0 SHALL mean no delay stages.
REQ-013 SHALL register all outputs; timing latency SHALL be SYNC_DELAY+1 cycles and colour latency 1 cycle.
REQ-014 SHALL drive o_red/o_green/o_blue to 0 in any cycle after de_d was 0 (blanking).
REQ-015 SHALL, with dither inactive, output the top OUT_W bits of each component (truncation); OUT_W=IN_W SHALL pass colour through unchanged.
REQ-016 SHALL hold x parity xp: toggles each cycle de_d=1, cleared to 0 when de_d=0.
REQ-017 SHALL hold y parity yp: toggles on each falling edge of de_d, cleared to 0 when frame_d=1; frame_d clear SHALL win when both occur in the same cycle.
REQ-018 SHALL latch i_dither_en into dither_act only in cycles where frame_d=1; changes mid-frame SHALL take effect at the next frame.
REQ-019 SHALL, when dither_act=1, add threshold T = B << (IN_W-OUT_W-2) to each component before truncation, with B indexed (yp,xp): (0,0)=0, (0,1)=2, (1,0)=3, (1,1)=1.
REQ-020 SHALL saturate: if the IN_W+1-bit sum exceeds 2^IN_W-1, the output component SHALL be all ones.
REQ-021 SHALL force dither_act to 0 when IN_W-OUT_W < 2.
REQ-022 SHALL apply identical processing to all three components in the same cycle.

Reset
REQ-023 SHALL, while i_rst_n=0, immediately drive o_de, o_frame and all colour outputs to 0, and o_hs/o_vs to the inactive level (~H_POL, ~V_POL).
REQ-024 SHALL reset all delay stages to the same inactive values, and xp, yp and dither_act to 0.
REQ-025 SHALL, after release, produce no spurious sync or de pulse; first valid output appears SYNC_DELAY+1 cycles after first valid input.

Verification (IN_W=8, OUT_W=4, SYNC_DELAY=2, H_POL=V_POL=0)
REQ-026 Reset: drop i_rst_n mid-line, no clock edge -> o_hs=o_vs=1, o_de=0, colour 0 at once; after release, outputs stay inactive for 3 cycles.
REQ-027 Alignment: i_de rises at cycle 10, i_red=0xA7 at cycle 12 -> o_de=1 and o_red=0xA at cycle 13.
REQ-028 Blanking: i_de=0, all colour 0xFF -> all colour outputs 0.
REQ-029 Dither: i_dither_en=1, frame pulse, two lines of four pixels i_red=0x18 -> line 0: 1,2,1,2; line 1: 2,1,2,1.
REQ-030 Saturation: dither active, i_red=0xFE at (yp,xp)=(1,0) -> o_red=0xF, no wrap to 0x0.
REQ-031 Mid-frame enable: raise i_dither_en mid-frame with i_red=0x18 -> output constant 0x1 until next frame_d, then dither pattern.
